// File: rtl/fp16_argmax_if.sv
// Stream-in / result-out bundle for fp16_argmax; runner-up fields exist only
// when ARGMAX_RUNNERUP_EN is defined.
interface fp16_argmax_if #(
   parameter int NUM_CLASSES = 10,
   parameter int WIDTH       = 16,
   parameter int IDX_W       = $clog2(NUM_CLASSES)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_score;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_class;
   logic [WIDTH-1:0] out_score;
   logic [IDX_W:0]   out_count;
   logic             out_nan;
`ifdef ARGMAX_RUNNERUP_EN
   logic [IDX_W-1:0] out_class2;
   logic [WIDTH-1:0] out_score2;
`endif

   modport master (
      output in_valid, in_score, in_last, out_ready,
`ifdef ARGMAX_RUNNERUP_EN
      input  out_class2, out_score2,
`endif
      input  in_ready, out_valid, out_class, out_score, out_count, out_nan
   );

   modport slave (
      input  in_valid, in_score, in_last, out_ready,
`ifdef ARGMAX_RUNNERUP_EN
      output out_class2, out_score2,
`endif
      output in_ready, out_valid, out_class, out_score, out_count, out_nan
   );
endinterface

// File: rtl/fp16_argmax.sv
// Streaming FP16 argmax over NUM_CLASSES scores with a valid/ready result.
// Define ARGMAX_RUNNERUP_EN to also track the second-best score and class.
module fp16_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int WIDTH       = 16,
   parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
   input logic          clk,
   input logic          rst_n,
   input logic          clear,
   fp16_argmax_if.slave bus
);
   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(NUM_CLASSES);
   localparam logic [IDX_W:0] ONE        = (IDX_W+1)'(1);

   typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] best_score;
   logic [IDX_W-1:0] best_class;
   logic [IDX_W:0]   count;
   logic [IDX_W:0]   count_inc;
   logic [IDX_W-1:0] new_class;
   logic             xfer;
   logic             done;
   logic             take_result;
   logic             new_best;

   function automatic logic is_nan(input logic [WIDTH-1:0] v);
      return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
   endfunction

   // Signed magnitude key: both zeros map to 0, infinities sit at the ends.
   function automatic logic signed [WIDTH:0] order_key(input logic [WIDTH-1:0] v);
      logic signed [WIDTH:0] mag;
      mag = {2'b00, v[WIDTH-2:0]};
      return v[WIDTH-1] ? -mag : mag;
   endfunction

   function automatic logic beats(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (is_nan(a)) return 1'b0;
      if (is_nan(b)) return 1'b1;
      return order_key(a) > order_key(b);
   endfunction

   assign xfer        = bus.in_valid && bus.in_ready;
   assign count_inc   = count + ONE;
   assign new_class   = count[IDX_W-1:0];
   assign done        = bus.in_last || (count_inc == FULL_COUNT);
   assign take_result = (state == RESULT) && bus.out_ready;
   assign new_best    = (state == IDLE) || beats(bus.in_score, best_score);

   assign bus.in_ready  = (state != RESULT);
   assign bus.out_valid = (state == RESULT);
   assign bus.out_class = best_class;
   assign bus.out_score = best_score;
   assign bus.out_count = count;
   assign bus.out_nan   = (state == RESULT) && is_nan(best_score);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, COLLECT: if (xfer) state_next = done ? RESULT : COLLECT;
         RESULT:        if (bus.out_ready) state_next = IDLE;
         default:       state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   // The first score of a query always becomes the candidate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         best_score <= '0;
         best_class <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (xfer) begin
         count <= count_inc;
         if (new_best) begin
            best_score <= bus.in_score;
            best_class <= new_class;
         end
      end else if (take_result) begin
         count <= '0;
      end
   end

`ifdef ARGMAX_RUNNERUP_EN
   localparam logic [WIDTH-1:0] NEG_INF = WIDTH'(16'hFC00);

   logic [WIDTH-1:0] second_score;
   logic [IDX_W-1:0] second_class;

   // A displaced maximum becomes the runner-up; otherwise only a strict win replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         second_score <= NEG_INF;
         second_class <= '0;
      end else if (clear) begin
         second_score <= NEG_INF;
         second_class <= '0;
      end else if (xfer) begin
         if (state == IDLE) begin
            second_score <= NEG_INF;
            second_class <= '0;
         end else if (new_best) begin
            second_score <= best_score;
            second_class <= best_class;
         end else if (beats(bus.in_score, second_score)) begin
            second_score <= bus.in_score;
            second_class <= new_class;
         end
      end
   end

   assign bus.out_class2 = second_class;
   assign bus.out_score2 = second_score;
`endif
endmodule

// File: tb/tb_fp16_argmax.sv
// Bench for fp16_argmax: directed queries with literal expectations plus random
// queries checked every cycle against a real-valued argmax model.
module tb_fp16_argmax;
   localparam int NUM_CLASSES = 10;
   localparam int IDX_W       = $clog2(NUM_CLASSES);

   logic clk = 1'b0;
   logic rst_n;
   logic clear;

   int compared   = 0;
   int mismatched = 0;

   fp16_argmax_if #(.NUM_CLASSES(NUM_CLASSES)) bus();

   fp16_argmax #(.NUM_CLASSES(NUM_CLASSES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   logic [15:0] m_scores[$];
   bit          m_result = 1'b0;
   int          exp_class;
   logic [15:0] exp_score;
   bit          exp_nan;
   int          exp_class2;
   logic [15:0] exp_score2;

   logic [15:0] res_score;
   logic [15:0] res_score2;
   int          res_class;
   int          res_class2;
   int          res_count;
   bit          res_nan;

   logic [15:0] s[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic real pow2(input int k);
      real p = 1.0;
      int  n = (k < 0) ? -k : k;
      for (int i = 0; i < n; i++) p = (k < 0) ? p / 2.0 : p * 2.0;
      return p;
   endfunction

   function automatic bit is_nan_model(input logic [15:0] v);
      return (v[14:10] == 5'd31) && (v[9:0] != 10'd0);
   endfunction

   // Infinity maps beyond the largest finite half (65504).
   function automatic real to_real(input logic [15:0] v);
      int  e = int'(v[14:10]);
      int  m = int'(v[9:0]);
      real r;
      if (e == 31)     r = 1.0e9;
      else if (e == 0) r = real'(m) * pow2(-24);
      else             r = real'(m + 1024) * pow2(e - 25);
      return v[15] ? -r : r;
   endfunction

   function automatic bit better(input logic [15:0] a, input logic [15:0] b);
      if (is_nan_model(a)) return 1'b0;
      if (is_nan_model(b)) return 1'b1;
      return to_real(a) > to_real(b);
   endfunction

   task automatic modelQuery(input logic [15:0] q[$]);
      int bi = -1;
      int si = 0;
      logic [15:0] sv = 16'hFC00;
      int ci = 0;
      for (int i = 0; i < q.size(); i++)
         if (!is_nan_model(q[i]) && (bi < 0 || to_real(q[i]) > to_real(q[bi]))) bi = i;
      if (bi < 0) begin
         exp_class = 0; exp_score = q[0]; exp_nan = 1'b1;
      end else begin
         exp_class = bi; exp_score = q[bi]; exp_nan = 1'b0;
      end
      for (int i = 1; i < q.size(); i++) begin
         if (better(q[i], q[ci])) begin
            sv = q[ci]; si = ci; ci = i;
         end else if (better(q[i], sv)) begin
            sv = q[i]; si = i;
         end
      end
      exp_class2 = si;
      exp_score2 = sv;
   endtask

   // Check the outputs, then advance the model by what the coming edge commits.
   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
         checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
         checkOutput("rst_out_count", 32'(bus.out_count), 32'd0);
         m_scores.delete();
         m_result = 1'b0;
      end else begin
         checkOutput("in_ready", 32'(bus.in_ready), 32'(!m_result));
         checkOutput("out_valid", 32'(bus.out_valid), 32'(m_result));
         if (m_result) begin
            checkOutput("out_class", 32'(bus.out_class), 32'(exp_class));
            checkOutput("out_score", 32'(bus.out_score), 32'(exp_score));
            checkOutput("out_count", 32'(bus.out_count), 32'(m_scores.size()));
            checkOutput("out_nan", 32'(bus.out_nan), 32'(exp_nan));
`ifdef ARGMAX_RUNNERUP_EN
            checkOutput("out_class2", 32'(bus.out_class2), 32'(exp_class2));
            checkOutput("out_score2", 32'(bus.out_score2), 32'(exp_score2));
`endif
         end
         if (clear) begin
            m_scores.delete();
            m_result = 1'b0;
         end else if (m_result) begin
            if (bus.out_ready) begin
               m_result = 1'b0;
               m_scores.delete();
            end
         end else if (bus.in_valid) begin
            m_scores.push_back(bus.in_score);
            if (bus.in_last || m_scores.size() == NUM_CLASSES) begin
               m_result = 1'b1;
               modelQuery(m_scores);
            end
         end
      end
   end

   function automatic logic [15:0] rand_score();
      logic       sg   = 1'($urandom_range(0, 1));
      logic [9:0] mant = 10'($urandom_range(1, 1023));
      case ($urandom_range(0, 9))
         0:       return {sg, 5'h1F, mant};
         1:       return {sg, 5'h1F, 10'h000};
         2:       return {sg, 15'h0000};
         3:       return {sg, 5'h00, mant};
         4:       return 16'h4000;
         5:       return ($urandom_range(0, 1) != 0) ? 16'h3C00 : 16'hBC00;
         default: return {sg, 5'($urandom_range(1, 30)), 10'($urandom())};
      endcase
   endfunction

   task automatic applyStimulus(input logic [15:0] q[$], input bit use_last, input int gap, input int hold);
      int lat = 0;
      for (int i = 0; i < q.size(); i++) begin
         bus.in_valid  = 1'b1;
         bus.in_score  = q[i];
         bus.in_last   = use_last && (i == q.size() - 1);
         bus.out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (gap > 0 && i < q.size() - 1 && $urandom_range(0, 1) != 0) begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
         end
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'd0);
      repeat (hold) begin @(posedge clk); #1; end
      res_class = int'(bus.out_class);
      res_score = bus.out_score;
      res_count = int'(bus.out_count);
      res_nan   = bus.out_nan;
`ifdef ARGMAX_RUNNERUP_EN
      res_class2 = int'(bus.out_class2);
      res_score2 = bus.out_score2;
`endif
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0;
      bus.in_valid = 1'b0; bus.in_score = 16'h0000; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      #1;
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset_out_score", 32'(bus.out_score), 32'd0);
      checkOutput("reset_out_class", 32'(bus.out_class), 32'd0);
      checkOutput("reset_out_nan", 32'(bus.out_nan), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      s = '{16'h3C00, 16'h4000, 16'hBC00, 16'h3E00};
      applyStimulus(s, 1'b1, 0, 0);
      checkOutput("basic_class", 32'(res_class), 32'd1);
      checkOutput("basic_score", 32'(res_score), 32'h4000);
      checkOutput("basic_count", 32'(res_count), 32'd4);

      s = '{16'h4000, 16'h4000, 16'h3C00};
      applyStimulus(s, 1'b1, 0, 0);
      checkOutput("tie_class", 32'(res_class), 32'd0);

      s = '{16'h8000, 16'h0000};
      applyStimulus(s, 1'b1, 0, 1);
      checkOutput("zero_tie_class", 32'(res_class), 32'd0);

      s = '{16'h7E00, 16'hBC00, 16'h7E00};
      applyStimulus(s, 1'b1, 0, 0);
      checkOutput("nan_mix_class", 32'(res_class), 32'd1);
      checkOutput("nan_mix_nan", 32'(res_nan), 32'd0);

      s = '{16'h7E00, 16'h7E00, 16'h7E00};
      applyStimulus(s, 1'b1, 0, 0);
      checkOutput("all_nan_class", 32'(res_class), 32'd0);
      checkOutput("all_nan_flag", 32'(res_nan), 32'd1);
      checkOutput("all_nan_score", 32'(res_score), 32'h7E00);

      s = '{16'h3C00, 16'h4000, 16'hC000, 16'h0001, 16'h7BFF,
            16'h4200, 16'hFC00, 16'h0000, 16'h3800, 16'h7C00};
      applyStimulus(s, 1'b0, 1, 5);
      checkOutput("full_class", 32'(res_class), 32'd9);
      checkOutput("full_score", 32'(res_score), 32'h7C00);
      checkOutput("full_count", 32'(res_count), 32'd10);
      checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("idle_out_count", 32'(bus.out_count), 32'd0);

      bus.in_valid = 1'b1; bus.in_score = 16'h4400;
      @(posedge clk); #1;
      bus.in_score = 16'h4200;
      @(posedge clk); #1;
      clear = 1'b1; bus.in_score = 16'h4800;
      @(posedge clk); #1;
      clear = 1'b0; bus.in_valid = 1'b0;
      checkOutput("clear_count", 32'(bus.out_count), 32'd0);
      s = '{16'h3C00};
      applyStimulus(s, 1'b1, 0, 0);
      checkOutput("after_clear_class", 32'(res_class), 32'd0);
      checkOutput("after_clear_count", 32'(res_count), 32'd1);
      checkOutput("after_clear_score", 32'(res_score), 32'h3C00);

`ifdef ARGMAX_RUNNERUP_EN
      s = '{16'h3C00, 16'h4200, 16'h4000};
      applyStimulus(s, 1'b1, 0, 0);
      checkOutput("ru_class", 32'(res_class), 32'd1);
      checkOutput("ru_score", 32'(res_score), 32'h4200);
      checkOutput("ru_class2", 32'(res_class2), 32'd2);
      checkOutput("ru_score2", 32'(res_score2), 32'h4000);
`endif

      for (int qn = 0; qn < 80; qn++) begin
         int n = $urandom_range(1, NUM_CLASSES);
         bit use_last = (n < NUM_CLASSES) || ($urandom_range(0, 1) != 0);
         s.delete();
         for (int i = 0; i < n; i++) s.push_back(rand_score());
         applyStimulus(s, use_last, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      bus.in_valid = 1'b1; bus.in_score = 16'h4400;
      @(posedge clk); #1;
      bus.in_score = 16'h4600;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_score", 32'(bus.out_score), 32'd0);
      checkOutput("midrst_out_count", 32'(bus.out_count), 32'd0);
      checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      s = '{16'hC400, 16'hC200};
      applyStimulus(s, 1'b1, 0, 0);
      checkOutput("post_rst_class", 32'(res_class), 32'd1);
      checkOutput("post_rst_count", 32'(res_count), 32'd2);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
